// File: rtl/switch_bounce_gen.sv
// switch_bounce_gen
// Emulates a mechanical switch with contact bounce. When the commanded level
// i_level differs from the current output, the output toggles, then bounces
// 2*BOUNCES more times with pseudo-random gaps taken from a 16-bit Galois LFSR,
// so it always comes to rest at the commanded level. It then stays stable for
// HOLD cycles, after which a one-cycle o_done pulse is issued. Commanded level
// changes are ignored while a sequence is running.
//
// Parameters:
//   BOUNCES  - extra toggle pairs before the output settles (0..255)
//   GLITCH_W - width of the random gap field; gaps are 1..2^GLITCH_W cycles
//   HOLD     - stable cycles after the last gap before o_done (>= 1)
//   SEED     - LFSR seed; 0 is replaced by 16'hACE1 because 0 locks the LFSR
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset
//   i_level  - clean commanded switch level
//   o_bounce - bouncing switch output
//   o_busy   - high while bouncing or settling
//   o_done   - one-cycle pulse once the output has been stable for HOLD cycles

module switch_bounce_gen #(
  parameter int unsigned BOUNCES  = 2,
  parameter int unsigned GLITCH_W = 3,
  parameter int unsigned HOLD     = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_bounce,
  output logic o_busy,
  output logic o_done
);

  localparam logic [15:0]       SEED_EFF   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0]       TAPS       = 16'hB400;
  localparam logic [8:0]        TRANS_INIT = 9'(2 * BOUNCES);
  localparam logic [31:0]       HOLD_INIT  = 32'(HOLD);
  localparam logic [GLITCH_W:0] GAP_ONE    = (GLITCH_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BOUNCE = 2'b01,
    SETTLE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              bounce_q, bounce_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [8:0]        trans_q, trans_d;
  logic [GLITCH_W:0] gap_q, gap_d;
  logic [31:0]       hold_q, hold_d;
  logic [15:0]       lfsr_q, lfsr_d;

  logic [15:0]       lfsr_next;
  logic [GLITCH_W:0] gap_load;

  // Right-shifting Galois LFSR: the bit shifted out decides whether the taps
  // are folded back in. A non-zero state can never step to zero.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

  // Gap length is taken from the LFSR state before it advances, offset by one
  // so that a zero field still gives a one-cycle gap.
  assign gap_load = {1'b0, lfsr_q[GLITCH_W-1:0]} + GAP_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bounce_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      trans_q  <= '0;
      gap_q    <= '0;
      hold_q   <= '0;
      lfsr_q   <= SEED_EFF;
    end else begin
      state_q  <= state_d;
      bounce_q <= bounce_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      trans_q  <= trans_d;
      gap_q    <= gap_d;
      hold_q   <= hold_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bounce_d = bounce_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    trans_d  = trans_q;
    gap_d    = gap_q;
    hold_d   = hold_q;
    lfsr_d   = lfsr_q;

    case (state_q)
      IDLE: begin
        if (i_level != bounce_q) begin
          bounce_d = ~bounce_q;
          busy_d   = 1'b1;
          trans_d  = TRANS_INIT;
          gap_d    = gap_load;
          lfsr_d   = lfsr_next;
          state_d  = BOUNCE;
        end
      end

      BOUNCE: begin
        // A gap of zero cannot be loaded; treating it like one keeps the
        // machine from getting stuck if it ever appears.
        if (gap_q > GAP_ONE) begin
          gap_d = gap_q - GAP_ONE;
        end else if (trans_q != 9'd0) begin
          bounce_d = ~bounce_q;
          trans_d  = trans_q - 9'd1;
          gap_d    = gap_load;
          lfsr_d   = lfsr_next;
        end else begin
          hold_d  = HOLD_INIT;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (hold_q > 32'd1) begin
          hold_d = hold_q - 32'd1;
        end else begin
          hold_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        // Unused encoding: recover to IDLE, keep the output level.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_bounce = bounce_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb_switch_bounce_gen
// Directed bench for switch_bounce_gen. One instance uses the default
// parameters, a second uses BOUNCES=0. Expected transition and done edges are
// hand-derived from the LFSR sequence starting at 16'hACE1:
//   lfsr: ACE1 -> E270 -> 7138 -> 389C -> 1C4E -> 0E27 -> B313 -> ED89 -> C2C4 -> 6162
//   gaps: 2, 1, 1, 5, 7 | 8, 4, 2, 5, 3
// Edge numbers count rising clk edges from the one that starts a sequence.

module tb_switch_bounce_gen;

  logic clk;
  logic rst;
  logic i_level;
  logic o_bounce;
  logic o_busy;
  logic o_done;
  logic i_level0;
  logic o_bounce0;
  logic o_busy0;
  logic o_done0;

  int total = 0;
  int bad   = 0;

  int exp_tog[$];
  int exp_done[$];

  bit   mon_en = 1'b0;
  logic mon_prev;
  int   mon_ntr;
  int   mon_gap;
  int   mon_started;
  int   mon_dones;

  switch_bounce_gen #(
    .BOUNCES(2), .GLITCH_W(3), .HOLD(8), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .i_level(i_level),
    .o_bounce(o_bounce), .o_busy(o_busy), .o_done(o_done)
  );

  switch_bounce_gen #(
    .BOUNCES(0), .GLITCH_W(3), .HOLD(8), .SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .rst(rst), .i_level(i_level0),
    .o_bounce(o_bounce0), .o_busy(o_busy0), .o_done(o_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_tog(input int e);
    foreach (exp_tog[i]) if (exp_tog[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_done(input int e);
    foreach (exp_done[i]) if (exp_done[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  // Steps ncyc edges, checking the default instance against the expected
  // toggle/done edge lists; optionally checks the BOUNCES=0 instance and
  // changes i_level after a given edge.
  task automatic check_run(input string tag, input int ncyc, input logic start_lvl,
                           input bit with0, input int chg_edge, input logic chg_val);
    logic lvl;
    logic busy_m;
    lvl    = start_lvl;
    busy_m = 1'b0;
    for (int e = 0; e < ncyc; e++) begin
      @(posedge clk);
      #1;
      if (is_tog(e)) begin
        lvl = ~lvl;
        busy_m = 1'b1;
      end
      if (is_done(e)) busy_m = 1'b0;
      check_output($sformatf("%s e%0d bounce", tag, e), o_bounce, lvl);
      check_output($sformatf("%s e%0d busy", tag, e), o_busy, busy_m);
      check_output($sformatf("%s e%0d done", tag, e), o_done, is_done(e));
      if (with0) begin
        check_output($sformatf("%s0 e%0d bounce", tag, e), o_bounce0, 1'b1);
        check_output($sformatf("%s0 e%0d busy", tag, e), o_busy0, (e < 10));
        check_output($sformatf("%s0 e%0d done", tag, e), o_done0, (e == 10));
      end
      if (e == chg_edge) i_level = chg_val;
    end
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, " bounce"}, o_bounce, 1'b0);
    check_output({tag, " busy"}, o_busy, 1'b0);
    check_output({tag, " done"}, o_done, 1'b0);
  endtask

  // Stress monitor: per sequence exactly five transitions, gaps of 1..8 edges,
  // and one done pulse per started sequence.
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst) begin
      mon_gap++;
      if (o_bounce !== mon_prev) begin
        if (mon_ntr == 0) mon_started++;
        else check_int($sformatf("stress gap=%0d in_range", mon_gap),
                       (mon_gap >= 1 && mon_gap <= 8) ? 1 : 0, 1);
        mon_ntr++;
        mon_gap = 0;
      end
      if (o_done) begin
        check_int("stress transitions", mon_ntr, 5);
        mon_dones++;
        mon_ntr = 0;
      end
      mon_prev = o_bounce;
    end
  end

  initial begin
    int w;
    rst      = 1'b1;
    i_level  = 1'b0;
    i_level0 = 1'b0;
    #3;
    check_zero("reset");
    check_output("reset bounce0", o_bounce0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle with matching level: nothing moves.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_zero($sformatf("idle%0d", k));
    end

    // Default sequence and clean BOUNCES=0 transition side by side.
    $display("[TB] default sequence");
    i_level  = 1'b1;
    i_level0 = 1'b1;
    exp_tog  = '{0, 2, 3, 4, 9};
    exp_done = '{24};
    check_run("seq", 30, 1'b0, 1'b1, -1, 1'b0);

    // Reset while idle at 1, then a sequence with i_level dropped mid-bounce;
    // the drop starts a second sequence one IDLE cycle after done.
    $display("[TB] ignored input");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("rst_idle");
    #1 rst = 1'b0;
    exp_tog  = '{0, 2, 3, 4, 9, 25, 33, 37, 39, 44};
    exp_done = '{24, 55};
    check_run("ign", 60, 1'b0, 1'b0, 1, 1'b0);

    // Reset mid-bounce after the third transition, then replay.
    $display("[TB] reset mid-operation");
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1 i_level = 1'b1;
    exp_tog  = '{0, 2, 3};
    exp_done = {};
    check_run("pre", 4, 1'b0, 1'b0, -1, 1'b0);
    #1 rst = 1'b1;
    #1 check_zero("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_zero($sformatf("rst_hold%0d", k));
    end
    rst = 1'b0;
    exp_tog  = '{0, 2, 3, 4, 9};
    exp_done = '{24};
    check_run("replay", 30, 1'b0, 1'b0, -1, 1'b0);

    // Random level changes with the monitor running.
    $display("[TB] stress");
    @(negedge clk);
    mon_prev    = o_bounce;
    mon_ntr     = 0;
    mon_gap     = 0;
    mon_started = 0;
    mon_dones   = 0;
    mon_en      = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(1, 40)) @(posedge clk);
      #1 i_level = ~i_level;
    end
    w = 0;
    while (o_busy && w < 500) begin
      @(posedge clk);
      #1 w++;
    end
    check_output("stress drain busy", o_busy, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    check_int("stress dones_vs_started", mon_dones, mon_started);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
